// File: rtl/urv_trap_ctrl.sv
// Machine-mode trap controller: owns the trap CSRs, arbitrates exceptions,
// interrupts and MRET in execute, and drives a fetch redirect until it is acknowledged.
module urv_trap_ctrl #(
    parameter logic [31:0] TRAP_VECTOR = 32'h00000008
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        x_stall_i,
    input  logic        x_kill_i,
    input  logic        x_valid_i,
    input  logic [31:0] x_pc_i,
    input  logic        x_is_csr_i,
    input  logic [11:0] x_csr_sel_i,
    input  logic [31:0] x_csr_write_value_i,
    input  logic        x_exception_i,
    input  logic [3:0]  x_exception_cause_i,
    input  logic        x_is_mret_i,
    input  logic        irq_ext_i,
    input  logic        irq_timer_i,
    output logic        x_trap_o,
    output logic        x_hold_o,
    output logic        f_redirect_o,
    output logic [31:0] f_redirect_pc_o,
    input  logic        f_redirect_ack_i,
    output logic [31:0] csr_mstatus_o,
    output logic [31:0] csr_mie_o,
    output logic [31:0] csr_mip_o,
    output logic [31:0] csr_mepc_o,
    output logic [31:0] csr_mcause_o,
    output logic        dbg_state_o
);

    // Redirect handshake: f_redirect_o stays high (with f_redirect_pc_o stable)
    // until the cycle in which f_redirect_ack_i is high; the request drops on that edge.

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } state_t;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    state_t      state_q;
    state_t      state_d;

    logic        mstatus_mie_q;
    logic        mstatus_mpie_q;
    logic        mie_mtie_q;
    logic        mie_meie_q;
    logic        mip_mtip_q;
    logic        mip_meip_q;
    logic [29:0] mepc_q;
    logic        mcause_irq_q;
    logic [3:0]  mcause_code_q;
    logic [31:0] redirect_pc_q;

    logic        go;
    logic        irq_ext_pend;
    logic        irq_timer_pend;
    logic        trap;
    logic        trap_irq;
    logic [3:0]  trap_code;
    logic        mret_take;
    logic        csr_we;

    assign irq_ext_pend   = mstatus_mie_q & mie_meie_q & mip_meip_q;
    assign irq_timer_pend = mstatus_mie_q & mie_mtie_q & mip_mtip_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Priority: exception, external irq, timer irq, then MRET, then CSR write.
    always_comb begin
        state_d      = state_q;
        f_redirect_o = 1'b0;
        x_hold_o     = 1'b0;
        x_trap_o     = 1'b0;
        go           = 1'b0;
        trap         = 1'b0;
        trap_irq     = 1'b0;
        trap_code    = x_exception_cause_i;
        mret_take    = 1'b0;
        csr_we       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                go = x_valid_i & ~x_stall_i & ~x_kill_i;
                if (go && (x_exception_i || irq_ext_pend || irq_timer_pend)) begin
                    trap     = 1'b1;
                    x_trap_o = 1'b1;
                    state_d  = ST_REDIRECT;
                    if (x_exception_i) begin
                        trap_irq  = 1'b0;
                        trap_code = x_exception_cause_i;
                    end else if (irq_ext_pend) begin
                        trap_irq  = 1'b1;
                        trap_code = 4'd11;
                    end else begin
                        trap_irq  = 1'b1;
                        trap_code = 4'd7;
                    end
                end else if (go && x_is_mret_i) begin
                    mret_take = 1'b1;
                    state_d   = ST_REDIRECT;
                end else if (go && x_is_csr_i) begin
                    csr_we = 1'b1;
                end
            end
            ST_REDIRECT: begin
                f_redirect_o = 1'b1;
                x_hold_o     = 1'b1;
                if (f_redirect_ack_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_mtie_q     <= 1'b0;
            mie_meie_q     <= 1'b0;
            mip_mtip_q     <= 1'b0;
            mip_meip_q     <= 1'b0;
            mepc_q         <= 30'd0;
            mcause_irq_q   <= 1'b0;
            mcause_code_q  <= 4'd0;
            redirect_pc_q  <= 32'd0;
        end else begin
            // Pending bits track the interrupt lines regardless of pipeline state.
            mip_mtip_q <= irq_timer_i;
            mip_meip_q <= irq_ext_i;
            if (trap) begin
                mepc_q         <= x_pc_i[31:2];
                mcause_irq_q   <= trap_irq;
                mcause_code_q  <= trap_code;
                mstatus_mpie_q <= mstatus_mie_q;
                mstatus_mie_q  <= 1'b0;
                redirect_pc_q  <= TRAP_VECTOR;
            end else if (mret_take) begin
                mstatus_mie_q  <= mstatus_mpie_q;
                mstatus_mpie_q <= 1'b1;
                redirect_pc_q  <= {mepc_q, 2'b00};
            end else if (csr_we) begin
                case (x_csr_sel_i)
                    CSR_MSTATUS: begin
                        mstatus_mie_q  <= x_csr_write_value_i[3];
                        mstatus_mpie_q <= x_csr_write_value_i[7];
                    end
                    CSR_MIE: begin
                        mie_mtie_q <= x_csr_write_value_i[7];
                        mie_meie_q <= x_csr_write_value_i[11];
                    end
                    CSR_MEPC: begin
                        mepc_q <= x_csr_write_value_i[31:2];
                    end
                    CSR_MCAUSE: begin
                        mcause_irq_q  <= x_csr_write_value_i[31];
                        mcause_code_q <= x_csr_write_value_i[3:0];
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign csr_mstatus_o   = {24'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
    assign csr_mie_o       = {20'd0, mie_meie_q, 3'd0, mie_mtie_q, 7'd0};
    assign csr_mip_o       = {20'd0, mip_meip_q, 3'd0, mip_mtip_q, 7'd0};
    assign csr_mepc_o      = {mepc_q, 2'b00};
    assign csr_mcause_o    = {mcause_irq_q, 27'd0, mcause_code_q};
    assign f_redirect_pc_o = redirect_pc_q;
    assign dbg_state_o     = (state_q == ST_REDIRECT);

    // Instructions are word aligned, so the PC low bits never reach mepc.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^x_pc_i[1:0];

endmodule

// File: tb/tb_urv_trap_ctrl.sv
// Bench for urv_trap_ctrl: directed scenarios plus random traffic, all checked
// against a CSR-level reference model.
module tb_urv_trap_ctrl;

    localparam logic [31:0] TRAP_VEC = 32'h00000008;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        x_stall_i;
    logic        x_kill_i;
    logic        x_valid_i;
    logic [31:0] x_pc_i;
    logic        x_is_csr_i;
    logic [11:0] x_csr_sel_i;
    logic [31:0] x_csr_write_value_i;
    logic        x_exception_i;
    logic [3:0]  x_exception_cause_i;
    logic        x_is_mret_i;
    logic        irq_ext_i;
    logic        irq_timer_i;
    logic        x_trap_o;
    logic        x_hold_o;
    logic        f_redirect_o;
    logic [31:0] f_redirect_pc_o;
    logic        f_redirect_ack_i;
    logic [31:0] csr_mstatus_o;
    logic [31:0] csr_mie_o;
    logic [31:0] csr_mip_o;
    logic [31:0] csr_mepc_o;
    logic [31:0] csr_mcause_o;
    logic        dbg_state_o;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: architectural CSR values plus "redirect outstanding".
    logic [31:0] m_mstatus, m_mie, m_mip, m_mepc, m_mcause, m_rpc;
    logic        m_redir;

    urv_trap_ctrl #(.TRAP_VECTOR(TRAP_VEC)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .x_stall_i(x_stall_i), .x_kill_i(x_kill_i), .x_valid_i(x_valid_i),
        .x_pc_i(x_pc_i), .x_is_csr_i(x_is_csr_i), .x_csr_sel_i(x_csr_sel_i),
        .x_csr_write_value_i(x_csr_write_value_i),
        .x_exception_i(x_exception_i), .x_exception_cause_i(x_exception_cause_i),
        .x_is_mret_i(x_is_mret_i), .irq_ext_i(irq_ext_i), .irq_timer_i(irq_timer_i),
        .x_trap_o(x_trap_o), .x_hold_o(x_hold_o),
        .f_redirect_o(f_redirect_o), .f_redirect_pc_o(f_redirect_pc_o),
        .f_redirect_ack_i(f_redirect_ack_i),
        .csr_mstatus_o(csr_mstatus_o), .csr_mie_o(csr_mie_o), .csr_mip_o(csr_mip_o),
        .csr_mepc_o(csr_mepc_o), .csr_mcause_o(csr_mcause_o),
        .dbg_state_o(dbg_state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mstatus = '0; m_mie = '0; m_mip = '0;
        m_mepc = '0; m_mcause = '0; m_rpc = '0; m_redir = 1'b0;
    endtask

    function automatic logic model_go();
        return !m_redir && x_valid_i && !x_stall_i && !x_kill_i;
    endfunction

    function automatic logic model_ext_pend();
        return m_mstatus[3] && m_mie[11] && m_mip[11];
    endfunction

    function automatic logic model_tmr_pend();
        return m_mstatus[3] && m_mie[7] && m_mip[7];
    endfunction

    function automatic logic model_trap();
        return model_go() && (x_exception_i || model_ext_pend() || model_tmr_pend());
    endfunction

    task automatic compare_all();
        chk("x_trap", {31'd0, x_trap_o}, {31'd0, model_trap()});
        chk("x_hold", {31'd0, x_hold_o}, {31'd0, m_redir});
        chk("f_redirect", {31'd0, f_redirect_o}, {31'd0, m_redir});
        chk("redirect_pc", f_redirect_pc_o, m_rpc);
        chk("state", {31'd0, dbg_state_o}, {31'd0, m_redir});
        chk("mstatus", csr_mstatus_o, m_mstatus);
        chk("mie", csr_mie_o, m_mie);
        chk("mip", csr_mip_o, m_mip);
        chk("mepc", csr_mepc_o, m_mepc);
        chk("mcause", csr_mcause_o, m_mcause);
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        logic go, trap, ext;
        go   = model_go();
        trap = model_trap();
        ext  = model_ext_pend();
        if (trap) begin
            m_mepc    = x_pc_i & 32'hFFFF_FFFC;
            if (x_exception_i)  m_mcause = {28'd0, x_exception_cause_i};
            else if (ext)       m_mcause = 32'h8000_000B;
            else                m_mcause = 32'h8000_0007;
            m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
            m_rpc     = TRAP_VEC;
            m_redir   = 1'b1;
        end else if (go && x_is_mret_i) begin
            m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
            m_rpc     = m_mepc;
            m_redir   = 1'b1;
        end else if (go && x_is_csr_i) begin
            case (x_csr_sel_i)
                12'h300: m_mstatus = x_csr_write_value_i & 32'h0000_0088;
                12'h304: m_mie     = x_csr_write_value_i & 32'h0000_0880;
                12'h341: m_mepc    = x_csr_write_value_i & 32'hFFFF_FFFC;
                12'h342: m_mcause  = x_csr_write_value_i & 32'h8000_000F;
                default: ;
            endcase
        end else if (m_redir && f_redirect_ack_i) begin
            m_redir = 1'b0;
        end
        m_mip = (irq_ext_i ? 32'h800 : 32'h0) | (irq_timer_i ? 32'h80 : 32'h0);
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic run_cycle();
        #1;
        compare_all();
        model_step();
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        x_stall_i = 0; x_kill_i = 0; x_valid_i = 0; x_pc_i = '0;
        x_is_csr_i = 0; x_csr_sel_i = '0; x_csr_write_value_i = '0;
        x_exception_i = 0; x_exception_cause_i = '0; x_is_mret_i = 0;
        f_redirect_ack_i = 0;
    endtask

    task automatic csr_write(input logic [11:0] sel, input logic [31:0] val);
        idle_inputs();
        x_valid_i = 1; x_is_csr_i = 1; x_csr_sel_i = sel; x_csr_write_value_i = val;
        x_pc_i = 32'h40;
        run_cycle();
        idle_inputs();
    endtask

    task automatic go_instr(input logic [31:0] pc, input logic exc, input logic [3:0] cause,
                            input logic mret, input logic exp_trap);
        idle_inputs();
        x_valid_i = 1; x_pc_i = pc; x_exception_i = exc;
        x_exception_cause_i = cause; x_is_mret_i = mret;
        #1;
        chk("go_trap", {31'd0, x_trap_o}, {31'd0, exp_trap});
        run_cycle();
        idle_inputs();
    endtask

    task automatic ack_redirect();
        idle_inputs();
        f_redirect_ack_i = 1;
        run_cycle();
        idle_inputs();
    endtask

    initial begin
        rst_i = 0; irq_ext_i = 0; irq_timer_i = 0;
        idle_inputs();
        model_reset();
        repeat (3) @(negedge clk_i);
        #1;
        compare_all();
        chk("rst_mstatus", csr_mstatus_o, 32'h0);
        @(negedge clk_i);
        rst_i = 1;

        // CSR write masks; mip ignores writes
        csr_write(12'h300, 32'hFFFF_FFFF);
        chk("mstatus_mask", csr_mstatus_o, 32'h0000_0088);
        csr_write(12'h304, 32'hFFFF_FFFF);
        chk("mie_mask", csr_mie_o, 32'h0000_0880);
        csr_write(12'h341, 32'hFFFF_FFFF);
        chk("mepc_mask", csr_mepc_o, 32'hFFFF_FFFC);
        csr_write(12'h342, 32'hFFFF_FFFF);
        chk("mcause_mask", csr_mcause_o, 32'h8000_000F);
        csr_write(12'h344, 32'hFFFF_FFFF);
        chk("mip_ro", csr_mip_o, 32'h0);
        csr_write(12'h300, 32'h0);
        csr_write(12'h304, 32'h0);

        // External interrupt trap and redirect handshake
        csr_write(12'h300, 32'h8);
        csr_write(12'h304, 32'h800);
        irq_ext_i = 1;
        idle_inputs(); run_cycle();
        go_instr(32'h100, 0, 4'd0, 0, 1);
        chk("ext_mepc", csr_mepc_o, 32'h100);
        chk("ext_mcause", csr_mcause_o, 32'h8000_000B);
        chk("ext_mstatus", csr_mstatus_o, 32'h80);
        chk("ext_rpc", f_redirect_pc_o, 32'h8);
        irq_ext_i = 0;
        repeat (2) begin
            idle_inputs(); run_cycle();
            chk("redir_held", {31'd0, f_redirect_o}, 32'd1);
        end
        ack_redirect();
        chk("redir_dropped", {31'd0, f_redirect_o}, 32'd0);

        // Exception beats a pending timer interrupt; timer waits for MRET
        csr_write(12'h300, 32'h8);
        csr_write(12'h304, 32'h80);
        irq_timer_i = 1;
        idle_inputs(); run_cycle();
        go_instr(32'h204, 1, 4'd2, 0, 1);
        chk("exc_mcause", csr_mcause_o, 32'h2);
        chk("exc_mepc", csr_mepc_o, 32'h204);
        ack_redirect();
        chk("tmr_still_pending", csr_mip_o, 32'h80);
        go_instr(32'h8, 0, 4'd0, 0, 0);
        go_instr(32'hC, 0, 4'd0, 1, 0);
        chk("mret_rpc", f_redirect_pc_o, 32'h204);
        chk("mret_mstatus", csr_mstatus_o, 32'h88);
        ack_redirect();
        go_instr(32'h208, 0, 4'd0, 0, 1);
        chk("tmr_mcause", csr_mcause_o, 32'h8000_0007);
        irq_timer_i = 0;
        ack_redirect();

        // MRET with MPIE set
        csr_write(12'h341, 32'h300);
        csr_write(12'h300, 32'h80);
        go_instr(32'h10, 0, 4'd0, 1, 0);
        chk("mret2_mstatus", csr_mstatus_o, 32'h88);
        chk("mret2_rpc", f_redirect_pc_o, 32'h300);
        ack_redirect();

        // Stalled cycles never trap
        csr_write(12'h304, 32'h800);
        irq_ext_i = 1;
        idle_inputs(); run_cycle();
        repeat (3) begin
            idle_inputs(); x_valid_i = 1; x_stall_i = 1; x_pc_i = 32'h50;
            #1; chk("stall_no_trap", {31'd0, x_trap_o}, 32'd0);
            run_cycle();
        end
        go_instr(32'h50, 0, 4'd0, 0, 1);
        chk("unstall_mcause", csr_mcause_o, 32'h8000_000B);
        chk("unstall_mepc", csr_mepc_o, 32'h50);
        irq_ext_i = 0;

        // Reset while redirecting
        #2;
        rst_i = 0;
        #1;
        chk("rst_redirect", {31'd0, f_redirect_o}, 32'd0);
        chk("rst_hold", {31'd0, x_hold_o}, 32'd0);
        chk("rst_state", {31'd0, dbg_state_o}, 32'd0);
        chk("rst_rpc", f_redirect_pc_o, 32'd0);
        chk("rst_csrs", csr_mstatus_o | csr_mie_o | csr_mip_o | csr_mepc_o | csr_mcause_o, 32'd0);
        model_reset();
        @(negedge clk_i);
        rst_i = 1;
        idle_inputs();

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            idle_inputs();
            x_valid_i           = ($urandom_range(0, 3) != 0);
            x_stall_i           = ($urandom_range(0, 5) == 0);
            x_kill_i            = ($urandom_range(0, 7) == 0);
            x_pc_i              = $urandom;
            x_exception_i       = ($urandom_range(0, 9) == 0);
            x_exception_cause_i = 4'($urandom_range(0, 15));
            x_is_mret_i         = ($urandom_range(0, 11) == 0);
            x_is_csr_i          = !x_is_mret_i && ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 5))
                0: x_csr_sel_i = 12'h300;
                1: x_csr_sel_i = 12'h304;
                2: x_csr_sel_i = 12'h341;
                3: x_csr_sel_i = 12'h342;
                4: x_csr_sel_i = 12'h344;
                default: x_csr_sel_i = 12'($urandom_range(0, 4095));
            endcase
            x_csr_write_value_i = $urandom;
            f_redirect_ack_i    = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0) irq_ext_i = ~irq_ext_i;
            if ($urandom_range(0, 9) == 0) irq_timer_i = ~irq_timer_i;
            run_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
